// File: rtl/sel_arbiter_if.sv
// Request/grant/data bundle between the two display sources and sel_arbiter.
// The slave side is the arbiter; the master side drives requests and data.
interface sel_arbiter_if #(
    parameter int WIDTH = 7
);
    logic             REQ_A;
    logic             REQ_B;
    logic             LOCK;
    logic [WIDTH-1:0] DATA_A;
    logic [WIDTH-1:0] DATA_B;
    logic             GNT_A;
    logic             GNT_B;
    logic             SEL;
    logic [WIDTH-1:0] OUT;
    logic [WIDTH-1:0] OUT_N;
    logic             VALID;

    modport master (
        output REQ_A, REQ_B, LOCK, DATA_A, DATA_B,
        input  GNT_A, GNT_B, SEL, OUT, OUT_N, VALID
    );

    modport slave (
        input  REQ_A, REQ_B, LOCK, DATA_A, DATA_B,
        output GNT_A, GNT_B, SEL, OUT, OUT_N, VALID
    );
endinterface

// File: rtl/sel_arbiter.sv
// Two-requester round-robin arbiter with bounded tenure under contention,
// driving the display selector and registering the selected word.
module sel_arbiter #(
    parameter int WIDTH = 7,
    parameter int HOLD  = 4
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    sel_arbiter_if.slave  bus
);
    localparam int            CW      = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);
    localparam logic          LAST_A  = 1'b0;
    localparam logic          LAST_B  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic [CW-1:0]    r_cnt;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             w_preempt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_next    = r_state;
        w_preempt = (r_cnt == CNT_MAX) && !bus.LOCK;
        case (r_state)
            IDLE: begin
                if (bus.REQ_A && bus.REQ_B)
                    w_next = (r_last == LAST_A) ? GRANT_B : GRANT_A;
                else if (bus.REQ_A)
                    w_next = GRANT_A;
                else if (bus.REQ_B)
                    w_next = GRANT_B;
            end
            GRANT_A: begin
                // A voluntary release wins over LOCK; LOCK only gates preemption.
                if (!bus.REQ_A)
                    w_next = bus.REQ_B ? GRANT_B : IDLE;
                else if (bus.REQ_B && w_preempt)
                    w_next = GRANT_B;
            end
            GRANT_B: begin
                if (!bus.REQ_B)
                    w_next = bus.REQ_A ? GRANT_A : IDLE;
                else if (bus.REQ_A && w_preempt)
                    w_next = GRANT_A;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_last  <= LAST_B;
            r_cnt   <= '0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            r_state <= w_next;
            r_gnt_a <= (w_next == GRANT_A);
            r_gnt_b <= (w_next == GRANT_B);

            if (w_next != r_state) begin
                r_cnt <= '0;
                if (w_next == GRANT_A)
                    r_last <= LAST_A;
                else if (w_next == GRANT_B)
                    r_last <= LAST_B;
            end else if (r_state != IDLE && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Datapath trails the grant by one cycle; IDLE keeps the last word.
            case (r_state)
                GRANT_A: begin
                    r_out   <= bus.DATA_A;
                    r_valid <= 1'b1;
                end
                GRANT_B: begin
                    r_out   <= bus.DATA_B;
                    r_valid <= 1'b1;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign bus.GNT_A = r_gnt_a;
    assign bus.GNT_B = r_gnt_b;
    assign bus.SEL   = r_gnt_b;
    assign bus.OUT   = r_out;
    assign bus.OUT_N = ~r_out;
    assign bus.VALID = r_valid;
endmodule
